// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared helpers, default formats and prototype taps for the FIR family
// Purpose: clog2 helper, default fixed-point formats with their derived widths,
//          the two-state burst FSM encoding and a 24-entry raised-cosine prototype.
// Ports:   none (package).
package fir_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam int DEF_NB_INPUT   = 8;
  localparam int DEF_NBF_INPUT  = 7;
  localparam int DEF_NB_OUTPUT  = 8;
  localparam int DEF_NBF_OUTPUT = 7;
  localparam int DEF_NB_COEFF   = 8;
  localparam int DEF_NBF_COEFF  = 7;
  localparam int DEF_N_PHASE    = 4;
  localparam int DEF_N_TAPS     = 6;

  // Full-precision product, growth-safe accumulator, and the width left after
  // rounding off the surplus fraction bits (before clamping to the output).
  localparam int NB_PROD = DEF_NB_INPUT + DEF_NB_COEFF;
  localparam int NB_ACC  = NB_PROD + clog2(DEF_N_TAPS);
  localparam int NBF_ACC = DEF_NBF_INPUT + DEF_NBF_COEFF;
  localparam int NB_SAT  = NB_ACC + 1 - (NBF_ACC - DEF_NBF_OUTPUT);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fir_state_e;

  // Raised-cosine prototype (rolloff 0.5, 4x oversampled, Q1.7), index n at t=(n-12)/4.
  localparam logic signed [DEF_NB_COEFF-1:0] RC_PROTO [24] = '{
    8'sd0,   8'sd1,   8'sd2,   8'sd3,   8'sd0,   -8'sd7,
    -8'sd15, -8'sd16, 8'sd0,   8'sd33,  8'sd76,  8'sd113,
    8'sd127, 8'sd113, 8'sd76,  8'sd33,  8'sd0,   -8'sd16,
    -8'sd15, -8'sd7,  8'sd0,   8'sd3,   8'sd2,   8'sd1
  };

endpackage

// File: rtl/round_sat.sv
// rtl/round_sat.sv - combinational round/truncate and saturate to a narrower format
// Purpose: drops NBF_IN-NBF_OUT fraction bits (optionally round-half-up) and clamps
//          the result into NB_OUT bits, flagging any clamp.
// Ports:   i_data (signed NB_IN in), o_data (signed NB_OUT out), o_sat (clamp flag out).
module round_sat
  import fir_pkg::*;
#(
  parameter int NB_IN   = NB_ACC,
  parameter int NBF_IN  = NBF_ACC,
  parameter int NB_OUT  = DEF_NB_OUTPUT,
  parameter int NBF_OUT = DEF_NBF_OUTPUT,
  parameter int ROUND   = 1
) (
  input  logic signed [NB_IN-1:0]  i_data,
  output logic signed [NB_OUT-1:0] o_data,
  output logic                     o_sat
);

  localparam int DROP   = NBF_IN - NBF_OUT;
  localparam int NB_SUM = NB_IN + 1;
  localparam int NB_SHR = NB_SUM - DROP;
  localparam logic [NB_SUM-1:0] HALF = (ROUND != 0) ? (NB_SUM'(1) << (DROP - 1)) : '0;

  logic [NB_SUM-1:0] sum;
  logic [NB_SHR-1:0] shr;
  logic              in_range;

  always_comb begin
    // One guard bit so adding the half-LSB can never wrap.
    sum      = {i_data[NB_IN-1], i_data} + HALF;
    shr      = NB_SHR'(sum >> DROP);
    // Representable only if every discarded integer bit equals the kept sign bit.
    in_range = (&shr[NB_SHR-1:NB_OUT-1]) || !(|shr[NB_SHR-1:NB_OUT-1]);
    o_sat    = !in_range;
    if (in_range) begin
      o_data = shr[NB_OUT-1:0];
    end else if (shr[NB_SHR-1]) begin
      o_data = {1'b1, {(NB_OUT-1){1'b0}}};
    end else begin
      o_data = {1'b0, {(NB_OUT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/polyphase_interp_fir.sv
// rtl/polyphase_interp_fir.sv - parametrised polyphase interpolating FIR
// Purpose: each accepted sample produces N_PHASE outputs, one per polyphase branch,
//          using run-time loadable coefficients, then rounds and saturates.
// Ports:   clock, i_reset (sync, active high);
//          i_data/i_valid/o_ready input handshake;
//          i_coeff_we/i_coeff_addr/i_coeff_data coefficient write (addr = phase*N_TAPS+tap);
//          o_data/o_valid/o_phase/o_sat output sample, its branch index and clamp flag.
module polyphase_interp_fir
  import fir_pkg::*;
#(
  parameter int NB_INPUT   = DEF_NB_INPUT,
  parameter int NBF_INPUT  = DEF_NBF_INPUT,
  parameter int NB_OUTPUT  = DEF_NB_OUTPUT,
  parameter int NBF_OUTPUT = DEF_NBF_OUTPUT,
  parameter int NB_COEFF   = DEF_NB_COEFF,
  parameter int NBF_COEFF  = DEF_NBF_COEFF,
  parameter int N_PHASE    = DEF_N_PHASE,
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int ROUND      = 1
) (
  input  logic                                clock,
  input  logic                                i_reset,
  input  logic signed [NB_INPUT-1:0]          i_data,
  input  logic                                i_valid,
  output logic                                o_ready,
  input  logic                                i_coeff_we,
  input  logic [clog2(N_PHASE*N_TAPS)-1:0]    i_coeff_addr,
  input  logic signed [NB_COEFF-1:0]          i_coeff_data,
  output logic signed [NB_OUTPUT-1:0]         o_data,
  output logic                                o_valid,
  output logic [clog2(N_PHASE)-1:0]           o_phase,
  output logic                                o_sat
);

  localparam int CA_W   = clog2(N_PHASE * N_TAPS);
  localparam int PH_W   = clog2(N_PHASE);
  localparam int PROD_W = NB_INPUT + NB_COEFF;
  localparam int ACC_W  = PROD_W + clog2(N_TAPS);
  localparam int ACC_F  = NBF_INPUT + NBF_COEFF;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(N_PHASE - 1);

  fir_state_e                  state_q, state_d;
  logic [PH_W-1:0]             phase_q, phase_d;
  logic signed [NB_INPUT-1:0]  tap_q   [N_TAPS];
  logic signed [NB_COEFF-1:0]  coeff_q [N_PHASE][N_TAPS];
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     acc_d, acc_q;
  logic                        acc_vld_q;
  logic [PH_W-1:0]             acc_phase_q;
  logic signed [NB_OUTPUT-1:0] rs_data, o_data_q;
  logic                        rs_sat, o_sat_q, o_valid_q;
  logic [PH_W-1:0]             o_phase_q;
  logic                        accept;

  // Ready again during the last phase so bursts can abut with no idle cycle.
  assign o_ready = (state_q == ST_IDLE) || (phase_q == LAST_PHASE);
  assign accept  = i_valid && o_ready;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          phase_d = '0;
        end
      end
      ST_BUSY: begin
        if (accept) begin
          phase_d = '0;
        end else if (phase_q == LAST_PHASE) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  // One branch per cycle: dot product of the current phase's coefficients with the taps.
  always_comb begin
    prod  = '0;
    acc_d = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      prod  = tap_q[k] * coeff_q[phase_q][k];
      acc_d = acc_d + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_TAPS; k++) tap_q[k] <= '0;
      for (int p = 0; p < N_PHASE; p++) begin
        for (int k = 0; k < N_TAPS; k++) coeff_q[p][k] <= '0;
      end
    end else begin
      if (accept) begin
        tap_q[0] <= i_data;
        for (int k = 1; k < N_TAPS; k++) tap_q[k] <= tap_q[k-1];
      end
      // Address decode only matches in-range locations, so others fall through.
      if (i_coeff_we) begin
        for (int p = 0; p < N_PHASE; p++) begin
          for (int k = 0; k < N_TAPS; k++) begin
            if (i_coeff_addr == CA_W'(p * N_TAPS + k)) coeff_q[p][k] <= i_coeff_data;
          end
        end
      end
    end
  end

  // Two-stage output: accumulator register, then rounded/saturated output register.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      acc_q       <= '0;
      acc_vld_q   <= 1'b0;
      acc_phase_q <= '0;
      o_data_q    <= '0;
      o_valid_q   <= 1'b0;
      o_phase_q   <= '0;
      o_sat_q     <= 1'b0;
    end else begin
      acc_vld_q <= (state_q == ST_BUSY);
      if (state_q == ST_BUSY) begin
        acc_q       <= acc_d;
        acc_phase_q <= phase_q;
      end
      o_valid_q <= acc_vld_q;
      if (acc_vld_q) begin
        o_data_q  <= rs_data;
        o_sat_q   <= rs_sat;
        o_phase_q <= acc_phase_q;
      end
    end
  end

  round_sat #(
    .NB_IN  (ACC_W),
    .NBF_IN (ACC_F),
    .NB_OUT (NB_OUTPUT),
    .NBF_OUT(NBF_OUTPUT),
    .ROUND  (ROUND)
  ) u_round_sat (
    .i_data(acc_q),
    .o_data(rs_data),
    .o_sat (rs_sat)
  );

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;
  assign o_phase = o_phase_q;
  assign o_sat   = o_sat_q;

endmodule

// File: tb/tb_polyphase_interp_fir.sv
// tb/tb_polyphase_interp_fir.sv - scoreboard bench for polyphase_interp_fir
module tb_polyphase_interp_fir;
  import fir_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              i_reset = 1'b1;
  logic              i_valid = 1'b0;
  logic              i_coeff_we = 1'b0;
  logic signed [7:0] i_data = '0;
  logic signed [7:0] i_coeff_data = '0;
  logic [4:0]        i_coeff_addr = '0;
  logic signed [7:0] o_data, t_data;
  logic              o_ready, o_valid, o_sat, t_ready, t_valid, t_sat;
  logic [1:0]        o_phase, t_phase;

  polyphase_interp_fir #(.ROUND(1)) dut (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
    .o_data(o_data), .o_valid(o_valid), .o_phase(o_phase), .o_sat(o_sat)
  );

  polyphase_interp_fir #(.ROUND(0)) dut_t (
    .clock(clock), .i_reset(i_reset), .i_data(i_data), .i_valid(i_valid), .o_ready(t_ready),
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
    .o_data(t_data), .o_valid(t_valid), .o_phase(t_phase), .o_sat(t_sat)
  );

  typedef struct {
    logic signed [7:0] data;
    logic [1:0]        phase;
    logic              sat;
  } exp_t;

  exp_t              sb_q[$];
  int                n_checks = 0;
  int                n_fail = 0;
  logic signed [7:0] m_tap[6];
  logic signed [7:0] m_coef[24];

  function automatic exp_t model(input int p, input int rnd);
    exp_t e;
    int   acc, s;
    acc = 0;
    for (int k = 0; k < 6; k++) acc += int'(m_tap[k]) * int'(m_coef[p*6+k]);
    if (rnd != 0) acc += 64;
    s = acc >>> 7;
    e.sat = 1'b0;
    if (s > 127) begin s = 127; e.sat = 1'b1; end
    else if (s < -128) begin s = -128; e.sat = 1'b1; end
    e.data  = 8'(s);
    e.phase = 2'(p);
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 6; k++) m_tap[k] = '0;
    for (int a = 0; a < 24; a++) m_coef[a] = '0;
  endtask

  task automatic model_shift(input logic signed [7:0] s);
    for (int k = 5; k > 0; k--) m_tap[k] = m_tap[k-1];
    m_tap[0] = s;
  endtask

  task automatic push_burst();
    for (int p = 0; p < 4; p++) sb_q.push_back(model(p, 1));
  endtask

  // Scoreboard consumer: every valid output must match the oldest expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!i_reset && o_valid === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got data=%0d phase=%0d sat=%0b, required no output", o_data, o_phase, o_sat);
      end else begin
        e = sb_q.pop_front();
        if ({o_data, o_phase, o_sat} !== {e.data, e.phase, e.sat}) begin
          n_fail++;
          $display("FAIL sb_output: got data=%0d phase=%0d sat=%0b, required data=%0d phase=%0d sat=%0b",
                   o_data, o_phase, o_sat, e.data, e.phase, e.sat);
        end
      end
    end
  end

  // All tasks below start and end 1ns after a rising edge.
  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_coeff_we = 1'b0;
    repeat (2) @(posedge clock);
    #1 i_reset = 1'b0;
    sb_q.delete();
    model_clear();
  endtask

  task automatic wcoef(input int addr, input logic signed [7:0] v);
    i_coeff_we = 1'b1; i_coeff_addr = 5'(addr); i_coeff_data = v;
    @(posedge clock); #1;
    i_coeff_we = 1'b0;
    if (addr < 24) m_coef[addr] = v;
  endtask

  task automatic send(input logic signed [7:0] s, input bit push);
    int guard;
    guard = 0;
    i_data = s; i_valid = 1'b1;
    @(negedge clock);
    while (o_ready !== 1'b1 && guard < 16) begin @(negedge clock); guard++; end
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: got o_ready=%b, required 1 within 16 cycles", o_ready);
      @(posedge clock); #1 i_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    i_valid = 1'b0;
    model_shift(s);
    if (push) push_burst();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin @(posedge clock); #1; guard++; end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d outputs outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clock); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock);
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b, required 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", o_valid); end
    n_checks++; if (o_data !== 8'sd0) begin n_fail++; $display("FAIL reset_data: got %0d, required 0", o_data); end
    n_checks++; if (o_phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d, required 0", o_phase); end
    n_checks++; if (o_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b, required 0", o_sat); end
    @(posedge clock); #1;
  endtask

  task automatic test_impulse();
    for (int p = 0; p < 4; p++) wcoef(p*6, 8'sd64);
    send(8'sd127, 1'b1);
    repeat (2) @(negedge clock);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL impulse_latency_early: got o_valid=%b, required 0", o_valid); end
    @(negedge clock);
    n_checks++;
    if ({o_valid, o_phase} !== {1'b1, 2'd0}) begin
      n_fail++; $display("FAIL impulse_latency: got o_valid=%b phase=%0d, required 1 phase 0", o_valid, o_phase);
    end
    @(posedge clock); #1;
    send(8'sd0, 1'b1);
    drain();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 6; k++) wcoef(k, 8'sd127);
    for (int n = 0; n < 6; n++) send(8'sd127, 1'b1);
    repeat (3) @(negedge clock);
    n_checks++;
    if ({o_phase, o_data, o_sat} !== {2'd0, 8'sd127, 1'b1}) begin
      n_fail++; $display("FAIL sat_pos: got phase=%0d data=%0d sat=%b, required phase 0 data 127 sat 1", o_phase, o_data, o_sat);
    end
    @(posedge clock); #1;
    for (int n = 0; n < 6; n++) send(-8'sd128, 1'b1);
    repeat (3) @(negedge clock);
    n_checks++;
    if ({o_phase, o_data, o_sat} !== {2'd0, -8'sd128, 1'b1}) begin
      n_fail++; $display("FAIL sat_neg: got phase=%0d data=%0d sat=%b, required phase 0 data -128 sat 1", o_phase, o_data, o_sat);
    end
    @(posedge clock); #1;
    drain();
  endtask

  task automatic test_rounding();
    do_reset();
    wcoef(0, 8'sd1);
    send(8'sd64, 1'b1);
    repeat (3) @(negedge clock);
    n_checks++; if (o_data !== 8'sd1) begin n_fail++; $display("FAIL round_pos: got %0d, required 1", o_data); end
    n_checks++; if (t_data !== 8'sd0) begin n_fail++; $display("FAIL trunc_pos: got %0d, required 0", t_data); end
    @(posedge clock); #1;
    send(-8'sd64, 1'b1);
    repeat (3) @(negedge clock);
    n_checks++; if (o_data !== 8'sd0) begin n_fail++; $display("FAIL round_neg: got %0d, required 0", o_data); end
    n_checks++; if (t_data !== -8'sd1) begin n_fail++; $display("FAIL trunc_neg: got %0d, required -1", t_data); end
    @(posedge clock); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    int accepted, ready_bad, gap;
    logic signed [7:0] s;
    accepted = 0; ready_bad = 0; gap = 0;
    do_reset();
    for (int a = 0; a < 24; a++) wcoef(a, RC_PROTO[a]);
    for (int c = 0; c < 40; c++) begin
      s = 8'($urandom);
      i_data = s; i_valid = 1'b1;
      @(negedge clock);
      if (o_ready !== ((c % 4) == 0)) ready_bad++;
      if (c >= 3 && o_valid !== 1'b1) gap++;
      if (o_ready === 1'b1) begin
        accepted++;
        model_shift(s);
        push_burst();
      end
      @(posedge clock); #1;
    end
    i_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (o_valid !== 1'b1) gap++;
    end
    @(posedge clock); #1;
    n_checks++; if (ready_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_pattern: got %0d bad cycles, required 0", ready_bad); end
    n_checks++; if (accepted !== 10) begin n_fail++; $display("FAIL b2b_accept_count: got %0d, required 10", accepted); end
    n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL b2b_valid_gap: got %0d gap cycles, required 0", gap); end
    drain();
    @(negedge clock);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_valid: got %b, required 0", o_valid); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_burst();
    int guard;
    guard = 0;
    for (int p = 0; p < 4; p++) wcoef(p*6, 8'sd64);
    send(8'sd127, 1'b1);
    @(negedge clock);
    while (!(o_valid === 1'b1 && o_phase === 2'd2) && guard < 10) begin @(negedge clock); guard++; end
    n_checks++;
    if (o_phase !== 2'd2) begin n_fail++; $display("FAIL midrst_reach_phase2: got phase %0d, required 2", o_phase); end
    #1;
    sb_q.delete();
    i_reset = 1'b1;
    @(posedge clock); #1;
    i_reset = 1'b0;
    model_clear();
    @(negedge clock);
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, required 0", o_valid); end
    n_checks++; if (o_data !== 8'sd0) begin n_fail++; $display("FAIL midrst_data: got %0d, required 0", o_data); end
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b, required 1", o_ready); end
    @(posedge clock); #1;
    repeat (4) @(posedge clock); #1;
    send(8'sd127, 1'b1);
    drain();
  endtask

  task automatic test_coeff_write();
    for (int p = 0; p < 4; p++) wcoef(p*6, 8'sd64);
    wcoef(24, 8'sd100);
    wcoef(31, -8'sd100);
    send(8'sd127, 1'b0);
    for (int p = 0; p < 3; p++) sb_q.push_back(model(p, 1));
    @(posedge clock); #1;
    wcoef(18, 8'sd32);
    sb_q.push_back(model(3, 1));
    send(8'sd127, 1'b1);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    test_reset();
    test_impulse();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_mid_burst();
    test_coeff_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/polyphase_interp_fir.md
Name: polyphase_interp_fir

Overview:
- Parametrised polyphase interpolating FIR, successor to the fixed 6-tap/4-phase raised-cosine filter.
- Generalises phase count, taps per phase and all fixed-point formats.
- Adds run-time loadable coefficients, a valid/ready input handshake, selectable round/truncate, and a saturation flag.
- Sits between the symbol mapper and the DAC path; each accepted input sample yields N_PHASE output samples.

Parameters:
NB_INPUT, 8, input word width
NBF_INPUT, 7, input fractional bits
NB_OUTPUT, 8, output word width
NBF_OUTPUT, 7, output fractional bits
NB_COEFF, 8, coefficient width (signed)
NBF_COEFF, 7, coefficient fractional bits
N_PHASE, 4, interpolation factor / number of polyphase branches (>=2)
N_TAPS, 6, taps per phase (>=2)
ROUND, 1, 1 = round-half-up, 0 = truncate

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_data  in  NB_INPUT  signed input sample
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample this cycle
i_coeff_we  in  1  coefficient write strobe
i_coeff_addr  in  clog2(N_PHASE*N_TAPS)  coefficient address = phase*N_TAPS + tap
i_coeff_data  in  NB_COEFF  signed coefficient value
o_data  out  NB_OUTPUT  signed output sample
o_valid  out  1  o_data valid
o_phase  out  clog2(N_PHASE)  phase index of o_data
o_sat  out  1  o_data was clamped (qualified by o_valid)

Behaviour:
- One clock domain (clock). Synchronous active-high reset i_reset.
- Reset clears all of the following to 0: taps, coefficient memory, phase counter, busy, o_data, o_valid, o_phase, o_sat. o_ready is 1 out of reset.
- Reset mid-burst aborts the burst. No output is produced for the remaining phases.
- Accept condition: i_valid && o_ready.
  - o_ready = !busy || (phase == N_PHASE-1). This allows back-to-back bursts with zero idle cycles.
- On accept:
  - Tap register shifts: tap[0] <= i_data, tap[k] <= tap[k-1].
  - phase <= 0, busy <= 1.
- Busy cycle:
  - acc = sum over k of coeff[phase*N_TAPS+k] * tap[k]. tap[0] is the newest sample.
  - Result is registered into o_data with o_valid=1 and o_phase=phase.
  - phase increments. After phase N_PHASE-1, busy <= 0 unless a new sample is accepted in the same cycle.
- Latency: sample accepted at edge t. The phase-0 output is valid after edge t+2. Phase p is valid after edge t+2+p.
- Throughput: 1 input per N_PHASE cycles. o_valid stays continuously high under continuous i_valid.
- o_valid=0 when idle. o_data holds its last value.
- Coefficient writes:
  - Allowed any cycle and take effect from the next computation cycle.
  - A write during a burst affects the remaining phases of that burst. This is the defined behaviour; no stall is applied.
  - Out-of-range addresses are ignored.
- Arithmetic:
  - Product width NB_INPUT+NB_COEFF.
  - Accumulator NB_ACC = NB_INPUT+NB_COEFF+clog2(N_TAPS), with NBF_ACC = NBF_INPUT+NBF_COEFF. No internal overflow is possible.
  - Requires NBF_ACC > NBF_OUTPUT.
- ROUND=1: add 2^(NBF_ACC-NBF_OUTPUT-1) in an NB_ACC+1 wide sum, then drop NBF_ACC-NBF_OUTPUT LSBs. ROUND=0: drop the LSBs only.
- Saturation:
  - Applied when the discarded integer MSBs are not all equal to the sign bit.
  - Clamp to +2^(NB_OUTPUT-1)-1 or -2^(NB_OUTPUT-1) according to sign.
  - o_sat=1 for that output only.

Decomposition:
- Shared package/include fir_pkg holds:
  - clog2 function;
  - derived localparams NB_PROD, NB_ACC, NBF_ACC, NB_SAT;
  - the 24-entry raised-cosine prototype table used by benches.
- One sub-module: round_sat (combinational rounding + saturation, parametrised by input/output formats, outputs data and sat flag). It is reused by other filters.

Test Plan:
All scenarios use default parameters.
1. Impulse: coeff[phase p, tap 0]=64 for all p, others 0. Accept sample 127, then zeros -> o_data 64,64,64,64 with o_phase 0..3, starting 2 cycles after accept. Next burst gives 0s. o_sat=0.
2. Saturation positive: phase-0 coeffs all 127, six accepted samples of 127 -> sixth burst phase 0 gives o_data=127, o_sat=1. Same with samples -128 -> o_data=-128, o_sat=1.
3. Rounding: coeff[0]=1, sample 64 -> ROUND=1 gives o_data=1, ROUND=0 gives 0. Sample -64 -> ROUND=1 gives 0, ROUND=0 gives -1.
4. Handshake: i_valid held high for 40 cycles -> o_ready high 1 cycle in 4 after the first accept. Exactly 10 samples accepted. o_valid continuous with o_phase 0,1,2,3,0,...
5. Reset mid-burst: i_reset asserted while o_phase=2 -> next cycle o_valid=0, o_data=0, o_ready=1. A subsequent impulse with no coefficient reload yields all-zero outputs.
6. Coefficient write during burst: write coeff[3*6+0]=32 while phase 1 is computing, sample 127 on tap 0 -> phase-3 output is 32 (rounded from 31.75), phases 0-2 unchanged.
